// File: rtl/mult_pipe_unit_pkg.sv
// Shared types and helpers for the pipelined RV32M multiply unit.
// XLEN lives here because the RS/CDB packet structs are sized by it.
package mult_pipe_unit_pkg;

    localparam int XLEN      = 32;
    localparam int ROB_TAG_W = 5;
    localparam int INST_W    = 32;

    // funct3[1:0] of the RV32M multiply group maps directly onto these codes
    typedef enum logic [1:0] {
        MUL    = 2'b00,
        MULH   = 2'b01,
        MULHSU = 2'b10,
        MULHU  = 2'b11
    } MULT_FUNC;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [XLEN-1:0]   NPC;
    } INST_INFO;

    typedef struct packed {
        logic                 ready;
        logic [XLEN-1:0]      rs1_value;
        logic [XLEN-1:0]      rs2_value;
        logic [ROB_TAG_W-1:0] rd_tag;
        logic                 spec;
        INST_INFO             instr;
    } INSTR_READY_ENTRY;

    typedef struct packed {
        logic                 valid;
        logic [XLEN-1:0]      value;
        logic [ROB_TAG_W-1:0] rob_tag;
        logic [INST_W-1:0]    inst;
        logic [XLEN-1:0]      NPC;
        logic                 spec;
    } EX_WR_PACKET;

    typedef struct packed {
        logic                 valid;
        logic                 spec;
        logic                 neg;
        logic                 hi_sel;
        logic [ROB_TAG_W-1:0] rd_tag;
        logic [INST_W-1:0]    inst;
        logic [XLEN-1:0]      NPC;
        logic [2*XLEN-1:0]    acc;
        logic [XLEN-1:0]      mcand;
        logic [XLEN-1:0]      mplier;
    } MULT_STAGE_ENTRY;

    // Depth must split XLEN evenly into per-stage multiplier slices
    function automatic bit num_stages_legal(input int n);
        return (n == 1) || (n == 2) || (n == 4) || (n == 8);
    endfunction

    function automatic MULT_FUNC mult_func_of(input logic [1:0] funct3_lo);
        return MULT_FUNC'(funct3_lo);
    endfunction

endpackage

// File: rtl/mult_pipe_stage.sv
// One slot of the multiply pipeline: folds BITS_PER_STAGE multiplier bits
// into the accumulator on the way in, holds the entry under backpressure,
// and drops speculative entries on a misprediction.
module mult_pipe_stage
    import mult_pipe_unit_pkg::*;
#(
    parameter int NUM_STAGES = 4,
    parameter int STAGE_IDX  = 0
) (
    input  logic            clock,
    input  logic            reset_n,
    input  MULT_STAGE_ENTRY prev_entry,
    input  logic            next_ready,
    input  logic            branch_determined,
    input  logic            branch_misprediction,
    output MULT_STAGE_ENTRY entry,
    output logic            load,
    output logic            kill
);

    localparam int BPS   = XLEN / NUM_STAGES;
    localparam int SHIFT = STAGE_IDX * BPS;

    MULT_STAGE_ENTRY   work;
    MULT_STAGE_ENTRY   payload;
    logic [2*XLEN-1:0] partial;
    logic              valid_q;
    logic              spec_q;

    // Add this stage's multiplier slice times the multiplicand at its weight
    always_comb begin
        work        = prev_entry;
        partial     = {{XLEN{1'b0}}, prev_entry.mcand} *
                      {{(2*XLEN-BPS){1'b0}}, prev_entry.mplier[BPS-1:0]};
        work.acc    = prev_entry.acc + (partial << SHIFT);
        work.mplier = prev_entry.mplier >> BPS;
    end

    assign load = ~valid_q | next_ready;
    assign kill = valid_q & spec_q & branch_misprediction;

    // Occupancy and speculation state: refill when free, otherwise hold and squash
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            spec_q  <= 1'b0;
        end else if (load) begin
            valid_q <= prev_entry.valid & ~(branch_misprediction & prev_entry.spec);
            spec_q  <= prev_entry.spec & ~branch_determined;
        end else begin
            if (branch_misprediction && spec_q)
                valid_q <= 1'b0;
            if (branch_determined)
                spec_q <= 1'b0;
        end
    end

    // Datapath payload needs no reset; it is only observed while valid
    always_ff @(posedge clock) begin
        if (load && prev_entry.valid)
            payload <= work;
    end

    // Present the payload with the live control bits overlaid
    always_comb begin
        entry       = payload;
        entry.valid = valid_q;
        entry.spec  = spec_q;
    end

endmodule

// File: rtl/mult_pipe_unit.sv
// Pipelined RV32M multiplier between the mult RS and the writeback arbiter.
// Optional feature macro: MULT_PIPE_PERF_CNT_EN adds issue/squash/stall counters.
module mult_pipe_unit
    import mult_pipe_unit_pkg::*;
#(
    parameter int NUM_STAGES = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  INSTR_READY_ENTRY ready_inst_entry,
    output logic             in_ready,
    input  logic             branch_determined,
    input  logic             branch_misprediction,
    output EX_WR_PACKET      mult_output,
    input  logic             out_ready,
    output logic             busy
`ifdef MULT_PIPE_PERF_CNT_EN
    ,
    output logic [31:0]      perf_issued,
    output logic [31:0]      perf_squashed,
    output logic [31:0]      perf_stall_cycles
`endif
);

    localparam bit NUM_STAGES_OK = num_stages_legal(NUM_STAGES);

    generate
        if (!NUM_STAGES_OK) begin : g_bad_num_stages
            $error("mult_pipe_unit: NUM_STAGES must be 1, 2, 4 or 8");
        end
    endgenerate

    MULT_STAGE_ENTRY       dec_entry;
    MULT_STAGE_ENTRY       stage_entry [NUM_STAGES];
    MULT_STAGE_ENTRY       last_entry;
    logic [NUM_STAGES-1:0] stage_load;
    logic [NUM_STAGES-1:0] stage_kill;
    logic [NUM_STAGES-1:0] stage_valid;
    logic [2*XLEN-1:0]     product;
    logic                  accept;
    logic                  a_neg;
    logic                  b_neg;
    MULT_FUNC              op;
    logic                  unused_last;

    assign in_ready = stage_load[0];
    assign accept   = ready_inst_entry.ready & in_ready &
                      ~(branch_misprediction & ready_inst_entry.spec);

    // Decode the variant and turn signed operands into magnitudes plus a sign flag
    always_comb begin
        op               = mult_func_of(ready_inst_entry.instr.inst[13:12]);
        a_neg            = ready_inst_entry.rs1_value[XLEN-1] & ((op == MULH) || (op == MULHSU));
        b_neg            = ready_inst_entry.rs2_value[XLEN-1] & (op == MULH);
        dec_entry        = '0;
        dec_entry.valid  = accept;
        dec_entry.spec   = ready_inst_entry.spec & ~branch_determined;
        dec_entry.neg    = a_neg ^ b_neg;
        dec_entry.hi_sel = (op != MUL);
        dec_entry.rd_tag = ready_inst_entry.rd_tag;
        dec_entry.inst   = ready_inst_entry.instr.inst;
        dec_entry.NPC    = ready_inst_entry.instr.NPC;
        dec_entry.mcand  = a_neg ? -ready_inst_entry.rs1_value : ready_inst_entry.rs1_value;
        dec_entry.mplier = b_neg ? -ready_inst_entry.rs2_value : ready_inst_entry.rs2_value;
    end

    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
        MULT_STAGE_ENTRY prev_link;
        logic            next_link;

        if (k == 0) begin : g_head
            assign prev_link = dec_entry;
        end else begin : g_body
            assign prev_link = stage_entry[k-1];
        end

        if (k == NUM_STAGES - 1) begin : g_tail
            assign next_link = out_ready;
        end else begin : g_inner
            assign next_link = stage_load[k+1];
        end

        mult_pipe_stage #(
            .NUM_STAGES (NUM_STAGES),
            .STAGE_IDX  (k)
        ) u_stage (
            .clock                (clock),
            .reset_n              (reset_n),
            .prev_entry           (prev_link),
            .next_ready           (next_link),
            .branch_determined    (branch_determined),
            .branch_misprediction (branch_misprediction),
            .entry                (stage_entry[k]),
            .load                 (stage_load[k]),
            .kill                 (stage_kill[k])
        );

        assign stage_valid[k] = stage_entry[k].valid;
    end

    assign last_entry  = stage_entry[NUM_STAGES-1];
    assign busy        = |stage_valid;
    assign unused_last = ^{last_entry.mcand, last_entry.mplier};

    // Restore the sign on the full-width product and pick the requested half
    always_comb begin
        product     = last_entry.neg ? -last_entry.acc : last_entry.acc;
        mult_output = '0;
        if (last_entry.valid) begin
            mult_output.valid   = 1'b1;
            mult_output.value   = last_entry.hi_sel ? product[2*XLEN-1:XLEN] : product[XLEN-1:0];
            mult_output.rob_tag = last_entry.rd_tag;
            mult_output.inst    = last_entry.inst;
            mult_output.NPC     = last_entry.NPC;
            mult_output.spec    = last_entry.spec;
        end
    end

`ifdef MULT_PIPE_PERF_CNT_EN
    logic [31:0] kill_count;

    // Count how many in-flight ops are being squashed this cycle
    always_comb begin
        kill_count = '0;
        for (int k = 0; k < NUM_STAGES; k++)
            kill_count = kill_count + {31'b0, stage_kill[k]};
    end

    // Free-running wrap-around performance counters
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            perf_issued       <= '0;
            perf_squashed     <= '0;
            perf_stall_cycles <= '0;
        end else begin
            if (accept)
                perf_issued <= perf_issued + 32'd1;
            perf_squashed <= perf_squashed + kill_count;
            if (ready_inst_entry.ready && !in_ready)
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
        end
    end
`else
    logic unused_kill;
    assign unused_kill = ^stage_kill;
`endif

endmodule
